// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one in-order read memory among NumReq req/gnt/rvalid requesters.
// Optional per-requester stall counters: define MEM_RR_ARB_STALL_CNT_EN.
module mem_rr_arb #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MemAddrWidth   = 12,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        mem_req_o,
  output logic [MemAddrWidth-1:0]     mem_addr_o,
  input  logic                        mem_rvalid_i,
  input  logic [DataWidth-1:0]        mem_rdata_i,
  output logic                        err_o,
  output logic [NumReq*16-1:0]        stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [IdxW-1:0] PtrRst = IdxW'(NumReq - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      winner_s, cand_s;
  logic                 found_s;
  logic [AddrWidth-1:0] win_addr_s;
  logic                 can_push_s, push_s, pop_s;
  logic [IdxW-1:0]      fifo_q [MaxOutstanding];
  logic [IdxW-1:0]      fifo_d [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 err_q, err_d;
  logic                 unused_addr_s;

  // Winner search starting one past the last granted requester.
  always_comb begin
    winner_s   = ptr_q;
    cand_s     = '0;
    found_s    = 1'b0;
    win_addr_s = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand_s = IdxW'((32'(ptr_q) + i) % NumReq);
      if (!found_s && req_i[cand_s]) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < int'(NumReq); k++) begin
      if (winner_s == IdxW'(k)) begin
        win_addr_s = addr_i[k*AddrWidth +: AddrWidth];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  assign unused_addr_s = ^{win_addr_s[AddrWidth-1:MemAddrWidth+2], win_addr_s[1:0]};

  // Request issue, response routing and ID FIFO / pointer next state.
  always_comb begin
    can_push_s = (count_q < CntMax) | mem_rvalid_i;
    push_s     = (|req_i) & can_push_s;
    pop_s      = mem_rvalid_i & (count_q != '0);
    gnt_o      = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    rvalid_o   = '0;
    rdata_o    = '0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ptr_d      = ptr_q;
    if (push_s) begin
      gnt_o            = NumReq'(1'b1) << winner_s;
      mem_req_o        = 1'b1;
      mem_addr_o       = win_addr_s[MemAddrWidth+1:2];
      fifo_d[wr_ptr_q] = winner_s;
      wr_ptr_d         = wr_ptr_q + PtrW'(1'b1);
      ptr_d            = winner_s;
    end else begin
      gnt_o = '0;
    end
    if (pop_s) begin
      rvalid_o = NumReq'(1'b1) << fifo_q[rd_ptr_q];
      rdata_o  = mem_rdata_i;
      rd_ptr_d = rd_ptr_q + PtrW'(1'b1);
    end else begin
      rvalid_o = '0;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntW'(1'b1);
      2'b01:   count_d = count_q - CntW'(1'b1);
      default: count_d = count_q;
    endcase
    // A response with nothing in flight is a protocol error that stays latched until reset.
    err_d = err_q | (mem_rvalid_i & (count_q == '0));
  end

  assign err_o = err_q;

  // Arbitration pointer, ID FIFO and error flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q    <= PtrRst;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef MEM_RR_ARB_STALL_CNT_EN
  logic [15:0] stall_q [NumReq];
  logic [15:0] stall_d [NumReq];

  // Saturating count of cycles each requester waits without a grant.
  always_comb begin
    stall_cnt_o = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      stall_d[k] = stall_q[k];
      if (req_i[k] && !gnt_o[k] && (stall_q[k] != 16'hFFFF)) begin
        stall_d[k] = stall_q[k] + 16'd1;
      end else begin
        stall_d[k] = stall_q[k];
      end
      stall_cnt_o[k*16 +: 16] = stall_q[k];
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '{default: '0};
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_rr_arb.sv
// Self-checking bench for mem_rr_arb (NumReq=3): vector table plus hand sequences,
// with a memory model and a response scoreboard.
module tb_mem_rr_arb;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int MAW = 12;
  localparam int DW  = 32;
  localparam int MO  = 4;
`ifdef MEM_RR_ARB_STALL_CNT_EN
  localparam logic [31:0] ExpStall5 = 32'd5;
  localparam logic [31:0] ExpStall6 = 32'd6;
`else
  localparam logic [31:0] ExpStall5 = 32'd0;
  localparam logic [31:0] ExpStall6 = 32'd0;
`endif

  logic            clk;
  logic            rst_ni;
  logic [NR-1:0]   req_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR-1:0]   gnt_o;
  logic [NR-1:0]   rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            mem_req_o;
  logic [MAW-1:0]  mem_addr_o;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            err_o;
  logic [NR*16-1:0] stall_cnt_o;

  mem_rr_arb #(
    .NumReq(NR), .AddrWidth(AW), .MemAddrWidth(MAW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [2:0] d_req; logic [2:0] e_gnt; } vec_t;
  typedef struct { logic [1:0] id; logic [31:0] data; } sb_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  sb_t  sbq[$];
  mem_t mq[$];
  vec_t vt[14];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   mem_stall = 1'b0;
  bit   inject = 1'b0;

  function automatic logic [31:0] addr_v(input int c, input int k);
    return 32'h0000_1234 + 32'(k) * (32'h0003_0000 + 32'(c) * 32'h44);
  endfunction

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, update models.
  task automatic cycle(input logic [2:0] req, input logic [2:0] exp_gnt);
    logic [31:0] a;
    logic [11:0] ea;
    int          k;
    sb_t         e;
    mem_t        m;
    req_i = req;
    for (int j = 0; j < NR; j++) addr_i[j*AW +: AW] = addr_v(cyc, j);
    if (!mem_stall && mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = m.data;
    end else if (inject) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end
    #1;
    ea = 12'h0;
    k  = -1;
    for (int j = 0; j < NR; j++) begin
      if (exp_gnt[j]) begin
        k  = j;
        a  = addr_v(cyc, j);
        ea = a[13:2];
      end
    end
    chk("gnt", 32'(gnt_o), 32'(exp_gnt));
    chk("mem_req", 32'(mem_req_o), 32'(|exp_gnt));
    chk("mem_addr", 32'(mem_addr_o), 32'(ea));
    if (mem_rvalid_i && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rvalid", 32'(rvalid_o), 32'(3'b001 << e.id));
      chk("rdata", rdata_o, e.data);
    end else begin
      chk("rvalid_idle", 32'(rvalid_o), 32'h0);
      chk("rdata_idle", rdata_o, 32'h0);
    end
    if (rst_ni && k >= 0) begin
      sbq.push_back('{id: 2'(k), data: data_of(ea)});
      mq.push_back('{data: data_of(mem_addr_o), due: cyc + lat});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    sbq.delete();
    mq.delete();
    for (int i = 0; i < n; i++) cycle(3'b000, 3'b000);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = '0;
    addr_i = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    vt[0]  = '{3'b111, 3'b001};
    vt[1]  = '{3'b111, 3'b010};
    vt[2]  = '{3'b111, 3'b100};
    vt[3]  = '{3'b111, 3'b001};
    vt[4]  = '{3'b111, 3'b010};
    vt[5]  = '{3'b111, 3'b100};
    vt[6]  = '{3'b001, 3'b001};
    vt[7]  = '{3'b000, 3'b000};
    vt[8]  = '{3'b100, 3'b100};
    vt[9]  = '{3'b011, 3'b001};
    vt[10] = '{3'b011, 3'b010};
    vt[11] = '{3'b110, 3'b100};
    vt[12] = '{3'b101, 3'b001};
    vt[13] = '{3'b010, 3'b010};
    @(negedge clk);

    do_reset(2);
    chk("err_after_reset", 32'(err_o), 32'h0);
    chk("stall_after_reset", 32'(stall_cnt_o), 32'h0);

    lat = 1;
    for (int i = 0; i < 14; i++) cycle(vt[i].d_req, vt[i].e_gnt);
    repeat (2) cycle(3'b000, 3'b000);
    chk("drain_table", 32'(sbq.size()), 32'h0);

    lat = 3;
    cycle(3'b001, 3'b001);
    cycle(3'b010, 3'b010);
    cycle(3'b001, 3'b001);
    repeat (4) cycle(3'b000, 3'b000);
    chk("drain_lat3", 32'(sbq.size()), 32'h0);

    chk("err_before_pulse", 32'(err_o), 32'h0);
    inject = 1'b1;
    cycle(3'b000, 3'b000);
    inject = 1'b0;
    chk("err_set", 32'(err_o), 32'h1);
    cycle(3'b000, 3'b000);
    chk("err_held", 32'(err_o), 32'h1);
    rst_ni = 1'b0;
    cycle(3'b100, 3'b100);
    rst_ni = 1'b1;
    chk("err_cleared", 32'(err_o), 32'h0);

    do_reset(1);
    lat = 1;
    mem_stall = 1'b1;
    repeat (4) cycle(3'b010, 3'b010);
    repeat (5) cycle(3'b011, 3'b000);
    chk("stall0_full", 32'(stall_cnt_o[15:0]), ExpStall5);
    chk("stall1_full", 32'(stall_cnt_o[31:16]), ExpStall5);
    chk("stall2_full", 32'(stall_cnt_o[47:32]), 32'h0);
    mem_stall = 1'b0;
    cycle(3'b011, 3'b001);
    chk("stall0_after", 32'(stall_cnt_o[15:0]), ExpStall5);
    chk("stall1_after", 32'(stall_cnt_o[31:16]), ExpStall6);
    repeat (6) cycle(3'b000, 3'b000);
    chk("drain_full", 32'(sbq.size()), 32'h0);
    chk("err_final", 32'(err_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
